// File: rtl/cbus_sram_responder.sv
// CBus responder backed by an on-chip 64-bit word array.
// Supports single and FIXED/INCR bursts with byte strobes and a programmable access latency.
// Revision: 1.0
`default_nettype none

package cbus_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  cbus_pkg::cbus_req_t  oreq,
  output cbus_pkg::cbus_resp_t oresp
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [3:0]  LAT4  = LATENCY[3:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BEAT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;

  logic             is_write_q;
  logic             incr_q;
  logic [3:0]       len_q;
  logic [3:0]       beat_cnt;
  logic [3:0]       delay_cnt;
  logic [IDX_W-1:0] idx;

  logic [63:0]      mem [DEPTH];

  logic [63:0]      offset;
  logic [IDX_W-1:0] req_idx;
  logic             accept;
  logic             beat_fire;
  logic             beat_last;
  logic             mem_we;

  // Out-of-window addresses simply wrap onto the array.
  assign offset  = oreq.addr - BASE;
  assign req_idx = offset[IDX_W+2:3];

  logic unused_bits;
  assign unused_bits = ^{oreq.size, offset[63:IDX_W+3], offset[2:0]};

  assign accept    = (state == S_IDLE) && oreq.valid;
  assign beat_fire = (state == S_BEAT) && oreq.valid;
  assign beat_last = beat_fire && (beat_cnt == len_q);
  assign mem_we    = beat_fire && is_write_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (oreq.valid) begin
          state_next = (LAT4 == 4'd0) ? S_BEAT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!oreq.valid) begin
          state_next = S_DRAIN;
        end else if (delay_cnt <= 4'd1) begin
          state_next = S_BEAT;
        end
      end
      S_BEAT: begin
        if (!oreq.valid || beat_last) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    oresp.ready = beat_fire;
    oresp.last  = beat_last;
    oresp.data  = 64'd0;
    if (beat_fire && !is_write_q) begin
      oresp.data = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_write_q <= 1'b0;
      incr_q     <= 1'b0;
      len_q      <= 4'd0;
      beat_cnt   <= 4'd0;
      delay_cnt  <= 4'd0;
      idx        <= '0;
    end else begin
      if (accept) begin
        is_write_q <= oreq.is_write;
        incr_q     <= (oreq.burst == cbus_pkg::BURST_INCR);
        len_q      <= oreq.len;
        beat_cnt   <= 4'd0;
        delay_cnt  <= LAT4;
        idx        <= req_idx;
      end else if (state == S_WAIT) begin
        delay_cnt <= delay_cnt - 4'd1;
      end else if (beat_fire && !beat_last) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (incr_q) begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Array is deliberately not reset; only strobed bytes are updated.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (oreq.strobe[b]) begin
          mem[idx][8*b +: 8] <= oreq.data[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire
